// File: rtl/seq_detector_prog.sv
// ---------------------------------------------------------------------------
// seq_detector_prog
//
// Run-time programmable serial bit-pattern detector. Bits arrive one per
// accepted cycle and are shifted into a history register. Each accepted bit is
// checked against a loadable pattern of up to PAT_W bits. On a match, a
// registered one-cycle detect pulse is raised and a saturating match counter
// is incremented.
//
// The matcher is a shift register plus a fill counter, with no encoded FSM.
// The fill counter records how many valid bits are in the history, so a match
// is only declared once at least 'len' real bits have been seen. When OVERLAP
// is 0, the fill counter is cleared on every match, so the next match has to
// be built from fresh bits.
//
// Parameters
//   PAT_W        maximum pattern length in bits (>= 2)
//   CNT_W        width of match_count
//   OVERLAP      1: trailing bits of a match may start the next one
//                0: matcher restarts after each match
//   DEFAULT_PAT  pattern after reset, right-aligned, MSB = first bit received
//   DEFAULT_LEN  pattern length after reset (1..PAT_W)
//
// Ports
//   clk          clock, everything on the rising edge
//   rst          synchronous reset, active-high
//   in_valid     qualifies 'in'; bits are only taken when high
//   in           serial data bit
//   cfg_load     one-cycle strobe that loads cfg_pattern / cfg_len
//   cfg_pattern  new pattern, right-aligned (bit cfg_len-1 received first)
//   cfg_len      new pattern length
//   clr_count    clears match_count on the next edge
//   out          detect pulse, high for one cycle per match
//   cfg_err      one-cycle pulse when a cfg_load carried an illegal length
//   match_count  saturating count of matches
// ---------------------------------------------------------------------------
module seq_detector_prog #(
   parameter int               PAT_W       = 4,
   parameter int               CNT_W       = 8,
   parameter bit               OVERLAP     = 1'b1,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1010),
   parameter int               DEFAULT_LEN = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in,
   input  logic                         cfg_load,
   input  logic [PAT_W-1:0]             cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
   input  logic                         clr_count,
   output logic                         out,
   output logic                         cfg_err,
   output logic [CNT_W-1:0]             match_count
);

   localparam int               LEN_W   = $clog2(PAT_W + 1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(DEFAULT_LEN);

   // Only PAT_W-1 bits of history are stored. The comparison always works on
   // the post-shift value {history, in}, so the oldest of PAT_W bits is shifted
   // out before it could ever be compared.
   logic [PAT_W-2:0] history;
   logic [LEN_W-1:0] fill;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] pat_len;

   logic             cfg_len_ok;
   logic             load_ok;
   logic             load_bad;
   logic             accept;
   logic [PAT_W-1:0] hist_shift;
   logic [LEN_W-1:0] fill_inc;
   logic [PAT_W-1:0] len_mask;
   logic             pat_hit;
   logic             match;
   logic             count_sat;

   // Decode the configuration strobe. A legal load takes priority over the
   // data bit in the same cycle, so the bit is dropped. A rejected load only
   // raises cfg_err and leaves the data path alone, so the bit is still
   // accepted in that cycle.
   always_comb begin
      cfg_len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN);
      load_ok    = cfg_load && cfg_len_ok;
      load_bad   = cfg_load && !cfg_len_ok;
      accept     = in_valid && !load_ok;
   end

   // Build the post-shift history and fill. Matching is judged on these
   // next-state values, so the pulse lines up with the edge that takes the
   // final pattern bit.
   always_comb begin
      hist_shift = {history, in};
      fill_inc   = (fill == MAX_LEN) ? fill : fill + LEN_W'(1);
   end

   // Compare only the low pat_len bits. Bits above the programmed length are
   // don't-care, both in the history and in the stored pattern.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         len_mask[i] = (i < int'(pat_len));
      end
      pat_hit = ((hist_shift ^ pattern) & len_mask) == '0;
   end

   // A match needs an accepted bit, enough real bits in the window and equal
   // masked contents. Bubble cycles can never produce a match.
   always_comb begin
      match     = accept && (fill_inc >= pat_len) && pat_hit;
      count_sat = (match_count == '1);
   end

   // Pattern registers change only on a legal load. After reset they go back
   // to the compiled-in default, which behaves like the original fixed
   // detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern <= DEFAULT_PAT;
         pat_len <= RST_LEN;
      end else if (load_ok) begin
         pattern <= cfg_pattern;
         pat_len <= cfg_len;
      end
   end

   // History and fill. A new pattern starts from an empty window, so stale
   // bits can never be matched against it. Bubble cycles hold the window, so
   // a partial sequence survives gaps in in_valid. With OVERLAP=0 the fill is
   // emptied on a match, while the history bits stay in place. This is safe
   // because no match can fire until fill has again reached pat_len, and by
   // then every compared bit is fresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         history <= '0;
         fill    <= '0;
      end else if (load_ok) begin
         history <= '0;
         fill    <= '0;
      end else if (accept) begin
         history <= hist_shift[PAT_W-2:0];
         if (match && (OVERLAP == 1'b0)) begin
            fill <= '0;
         end else begin
            fill <= fill_inc;
         end
      end
   end

   // Registered status pulses. Both are recomputed every cycle, so each
   // stays high for exactly one cycle per event. A legal load forces
   // match=0 because accept is low in that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out     <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         out     <= match;
         cfg_err <= load_bad;
      end
   end

   // Saturating match counter. A clear wins over a match in the same cycle.
   // Configuration loads never touch the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         match_count <= '0;
      end else if (clr_count) begin
         match_count <= '0;
      end else if (match && !count_sat) begin
         match_count <= match_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_detector_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_prog
//
// Directed bench for seq_detector_prog. Three instances cover the parameter
// variants:
//   dut_a : defaults (overlapping, 8-bit counter)
//   dut_b : OVERLAP=0
//   dut_c : CNT_W=2, used to exercise saturation
//
// The stimulus side drives one vector per cycle on the falling edge to the
// selected instance. Unselected instances sit idle. For each vector it queues
// the hand-computed response. A separate monitor samples just after each
// rising edge, pops the oldest expectation and compares out, cfg_err and
// match_count.
// ---------------------------------------------------------------------------
module tb_seq_detector_prog;

   typedef struct packed {
      logic [1:0] sel;
      logic       out;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   logic       clk;
   logic [2:0] rst_s;
   logic [2:0] in_valid_s;
   logic [2:0] in_s;
   logic [2:0] cfg_load_s;
   logic [3:0] cfg_pattern_s [3];
   logic [2:0] cfg_len_s [3];
   logic [2:0] clr_count_s;
   logic [2:0] out_s;
   logic [2:0] err_s;
   logic [7:0] cnt_a;
   logic [7:0] cnt_b;
   logic [1:0] cnt_c;

   exp_t       exp_q [$];
   string      tag_q [$];
   int         checks;
   int         errors;

   exp_t       mon_e;
   string      mon_tag;
   logic       act_out;
   logic       act_err;
   logic [7:0] act_cnt;

   seq_detector_prog #(.OVERLAP(1'b1)) dut_a (
      .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in(in_s[0]),
      .cfg_load(cfg_load_s[0]), .cfg_pattern(cfg_pattern_s[0]),
      .cfg_len(cfg_len_s[0]), .clr_count(clr_count_s[0]),
      .out(out_s[0]), .cfg_err(err_s[0]), .match_count(cnt_a)
   );

   seq_detector_prog #(.OVERLAP(1'b0)) dut_b (
      .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in(in_s[1]),
      .cfg_load(cfg_load_s[1]), .cfg_pattern(cfg_pattern_s[1]),
      .cfg_len(cfg_len_s[1]), .clr_count(clr_count_s[1]),
      .out(out_s[1]), .cfg_err(err_s[1]), .match_count(cnt_b)
   );

   seq_detector_prog #(.CNT_W(2)) dut_c (
      .clk(clk), .rst(rst_s[2]), .in_valid(in_valid_s[2]), .in(in_s[2]),
      .cfg_load(cfg_load_s[2]), .cfg_pattern(cfg_pattern_s[2]),
      .cfg_len(cfg_len_s[2]), .clr_count(clr_count_s[2]),
      .out(out_s[2]), .cfg_err(err_s[2]), .match_count(cnt_c)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record one comparison and report it if it does not hold.
   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle to instance 'sel' and queue its expected response.
   // All other instances get idle inputs.
   task automatic applyStimulus(input int sel, input logic r, input logic iv,
                                input logic b, input logic ld,
                                input logic [3:0] pat, input logic [2:0] len,
                                input logic clr, input logic e_out,
                                input logic e_err, input int e_cnt,
                                input string tag);
      exp_t e;
      @(negedge clk);
      rst_s       = '0;
      in_valid_s  = '0;
      in_s        = '0;
      cfg_load_s  = '0;
      clr_count_s = '0;
      for (int i = 0; i < 3; i++) begin
         cfg_pattern_s[i] = '0;
         cfg_len_s[i]     = '0;
      end
      rst_s[sel]         = r;
      in_valid_s[sel]    = iv;
      in_s[sel]          = b;
      cfg_load_s[sel]    = ld;
      cfg_pattern_s[sel] = pat;
      cfg_len_s[sel]     = len;
      clr_count_s[sel]   = clr;
      e.sel = 2'(sel);
      e.out = e_out;
      e.err = e_err;
      e.cnt = 8'(e_cnt);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic doReset(input int sel, input string tag);
      applyStimulus(sel, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0,
                    1'b0, 1'b0, 0, tag);
   endtask

   task automatic bubble(input int sel, input int cnt, input string tag);
      applyStimulus(sel, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0,
                    1'b0, 1'b0, cnt, tag);
   endtask

   // Feed n accepted bits, MSB of 'bits' first. 'outs' holds the
   // hand-computed detect pulse for each bit. The expected count follows
   // those pulses, starting at cnt0 and capped at cnt_max.
   task automatic streamCheck(input int sel, input int n, input logic [15:0] bits,
                              input logic [15:0] outs, input int cnt0,
                              input int cnt_max, input string tag);
      int   c;
      logic b;
      logic o;
      c = cnt0;
      for (int k = 0; k < n; k++) begin
         b = bits[n-1-k];
         o = outs[n-1-k];
         if (o && (c < cnt_max)) c++;
         applyStimulus(sel, 1'b0, 1'b1, b, 1'b0, 4'h0, 3'd0, 1'b0,
                       o, 1'b0, c, $sformatf("%s#%0d", tag, k + 1));
      end
   endtask

   // Monitor: after each rising edge, take the oldest pending expectation and
   // compare it with the instance it belongs to.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            case (mon_e.sel)
               2'd0:    begin act_out = out_s[0]; act_err = err_s[0]; act_cnt = cnt_a; end
               2'd1:    begin act_out = out_s[1]; act_err = err_s[1]; act_cnt = cnt_b; end
               default: begin act_out = out_s[2]; act_err = err_s[2]; act_cnt = {6'b0, cnt_c}; end
            endcase
            checkOutput({mon_tag, ".out"}, {7'b0, act_out}, {7'b0, mon_e.out});
            checkOutput({mon_tag, ".cfg_err"}, {7'b0, act_err}, {7'b0, mon_e.err});
            checkOutput({mon_tag, ".count"}, act_cnt, mon_e.cnt);
         end
      end
   end

   // Safety net in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rst_s       = '0;
      in_valid_s  = '0;
      in_s        = '0;
      cfg_load_s  = '0;
      clr_count_s = '0;
      for (int i = 0; i < 3; i++) begin
         cfg_pattern_s[i] = '0;
         cfg_len_s[i]     = '0;
      end

      // Test 1: default pattern 1010 with overlap. Matches after bits 4 and 6.
      doReset(0, "t1_rst");
      streamCheck(0, 6, 16'b101010, 16'b000101, 0, 255, "t1");

      // Test 2: non-overlapping. Bit 6 completes 1010 in the history,
      // but only two fresh bits have arrived since the last match.
      doReset(1, "t2_rst");
      streamCheck(1, 8, 16'b10101010, 16'b00010001, 0, 255, "t2");

      // Test 3: load 110/len 3 with a 1 presented in the same cycle. That
      // bit must be dropped: 1,0 afterwards stays silent. Reload, then
      // 110110 matches after bits 3 and 6. The count carries over.
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 3'd3, 1'b0,
                    1'b0, 1'b0, 2, "t3_load");
      streamCheck(0, 2, 16'b10, 16'b00, 2, 255, "t3_drop");
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 3'd3, 1'b0,
                    1'b0, 1'b0, 2, "t3_reload");
      streamCheck(0, 6, 16'b110110, 16'b001001, 2, 255, "t3");

      // Test 4: back to 1010. Bubbles inside the sequence are ignored.
      // Illegal lengths 0 and 5 pulse cfg_err and keep detecting 1010, and
      // the bit in the error cycle is still accepted.
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 3'd4, 1'b0,
                    1'b0, 1'b0, 4, "t4_load");
      streamCheck(0, 2, 16'b10, 16'b00, 4, 255, "t4_a");
      bubble(0, 4, "t4_bub1");
      bubble(0, 4, "t4_bub2");
      bubble(0, 4, "t4_bub3");
      streamCheck(0, 2, 16'b10, 16'b01, 4, 255, "t4_b");
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 3'd0, 1'b0,
                    1'b0, 1'b1, 5, "t4_len0");
      streamCheck(0, 3, 16'b010, 16'b101, 5, 255, "t4_c");
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 3'd5, 1'b0,
                    1'b0, 1'b1, 7, "t4_len5");
      streamCheck(0, 1, 16'b0, 16'b1, 7, 255, "t4_d");

      // Test 5: 2-bit counter saturates at 3 after five matches. A clear
      // that coincides with a match leaves the count at 0, and counting
      // resumes afterwards.
      doReset(2, "t5_rst");
      streamCheck(2, 12, 16'b101010101010, 16'b000101010101, 0, 3, "t5");
      applyStimulus(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0,
                    1'b0, 1'b0, 3, "t5_pre");
      applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b1,
                    1'b1, 1'b0, 0, "t5_clr");
      streamCheck(2, 2, 16'b10, 16'b01, 0, 3, "t5_post");

      // Test 6: a reset in the middle of 1,0,1 discards the partial match.
      // The trailing 0 must not complete the pattern.
      doReset(0, "t6_rst0");
      streamCheck(0, 3, 16'b101, 16'b000, 0, 255, "t6_a");
      doReset(0, "t6_rst1");
      streamCheck(0, 1, 16'b0, 16'b0, 0, 255, "t6_b");
      streamCheck(0, 4, 16'b1010, 16'b0001, 0, 255, "t6_c");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; (i < 10) && (exp_q.size() > 0); i++) begin
         @(posedge clk);
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
